// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver with output FIFO.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Two-out-of-three vote used to reject single-sample line noise.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received words with their error flags.
// A pop and a push in the same cycle are both honoured, even when full.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head word is forced to zero while empty so stale storage never shows on the outputs.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage write on an accepted push.
    // NOTE: the data array has no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// Oversampled UART receiver with majority-voted bit capture, optional parity,
// one or two stop bits, and an output FIFO with valid/ready handshake.
module uart_rx_frame_fifo
    import uart_pkg::*;
#(
    parameter int DATA_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                RxEn,
    input  logic                Rx,
    input  logic                Tick,
    input  logic [3:0]          NBits,
    input  logic                ParityEn,
    input  logic                ParityOdd,
    input  logic                TwoStop,
    output logic [DATA_MAX-1:0] RxData,
    output logic                RxParErr,
    output logic                RxFrmErr,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                Overrun,
    output logic                Busy
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam int FW  = DATA_MAX + 2;

    // Sample-counter positions: two early samples, the voting sample, and the bit boundary.
    localparam logic [SCW-1:0] SC_PRE  = SCW'(MID - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(MID);
    localparam logic [SCW-1:0] SC_VOTE = SCW'(MID + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     NB_MIN  = 4'd5;
    localparam logic [3:0]     NB_MAX  = 4'(DATA_MAX);

    // Line synchroniser.
    logic rx_meta_q;
    logic rx_sync_q;

    // Frame FSM and datapath state.
    rx_state_e           state_q,    state_d;
    logic [SCW-1:0]      sc_q,       sc_d;
    logic [3:0]          bit_cnt_q,  bit_cnt_d;
    logic [3:0]          nbits_q,    nbits_d;
    logic                par_en_q,   par_en_d;
    logic                par_odd_q,  par_odd_d;
    logic                two_stop_q, two_stop_d;
    logic [DATA_MAX-1:0] shreg_q,    shreg_d;
    logic [1:0]          samp_q,     samp_d;
    logic                par_err_q,  par_err_d;
    logic                frm_err_q,  frm_err_d;
    logic                stop2_q,    stop2_d;
    logic                armed_q,    armed_d;
    logic                overrun_q;

    // Per-cycle decode.
    logic                vote;
    logic                vote_tick;
    logic                bit_end;
    logic [3:0]          nbits_eff;
    logic [DATA_MAX-1:0] data_rj;
    logic                push;
    logic [FW-1:0]       push_word;

    // FIFO interface.
    logic [FW-1:0]       fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;

    // Two-flop synchroniser; resets to the idle (high) line level.
    // NOTE: flops use non-blocking assignments so each stage samples the previous value.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Out-of-range bit counts fall back to the widest supported frame.
    assign nbits_eff = (NBits < NB_MIN || NBits > NB_MAX) ? NB_MAX : NBits;

    // Vote once per bit from the samples either side of mid-bit plus the current one.
    assign vote      = majority3(samp_q[0], samp_q[1], rx_sync_q);
    assign vote_tick = Tick && (sc_q == SC_VOTE);
    assign bit_end   = Tick && (sc_q == SC_LAST);

    // Shifted-in bits collect at the top of shreg_q; move them down to bit 0.
    assign data_rj   = shreg_q >> (NB_MAX - nbits_q);

    // The final stop-bit vote is folded in here because the push happens in the voting cycle.
    assign push_word = {frm_err_q | ~vote, par_err_q, data_rj};

    // Frame FSM next-state, sample capture and error accumulation.
    // NOTE: every _d gets its hold value first so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        shreg_d    = shreg_q;
        samp_d     = samp_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        stop2_d    = stop2_q;
        armed_d    = armed_q;
        push       = 1'b0;

        if (state_q != ST_IDLE && Tick) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
            if (sc_q == SC_PRE) begin
                samp_d[0] = rx_sync_q;
            end
            if (sc_q == SC_MID) begin
                samp_d[1] = rx_sync_q;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                sc_d = '0;
                // A start edge only counts once the line has been seen high.
                if (rx_sync_q) begin
                    armed_d = 1'b1;
                end
                if (Tick && RxEn && !rx_sync_q && armed_q) begin
                    state_d    = ST_START;
                    sc_d       = SCW'(1);
                    armed_d    = 1'b0;
                    nbits_d    = nbits_eff;
                    par_en_d   = ParityEn;
                    par_odd_d  = ParityOdd;
                    two_stop_d = TwoStop;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    stop2_d    = 1'b0;
                end
            end

            ST_START: begin
                if (vote_tick && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end

            ST_DATA: begin
                if (vote_tick) begin
                    shreg_d = {vote, shreg_q[DATA_MAX-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (vote_tick) begin
                    par_err_d = ((^shreg_q) ^ vote) != par_odd_q;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (vote_tick) begin
                    frm_err_d = frm_err_q | ~vote;
                    if (!two_stop_q || stop2_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (bit_end) begin
                    stop2_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disabling the receiver discards any partial frame immediately.
        if (!RxEn) begin
            state_d = ST_IDLE;
            sc_d    = '0;
            push    = 1'b0;
        end
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            sc_q       <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            shreg_q    <= '0;
            samp_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            stop2_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            shreg_q    <= shreg_d;
            samp_q     <= samp_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            stop2_q    <= stop2_d;
            armed_q    <= armed_d;
        end
    end

    assign pop_fire = RxReady & ~fifo_empty;

    // Flag a completed frame that found no room; a same-cycle pop makes room instead.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push & fifo_full & ~pop_fire;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (RxReady),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign RxData   = fifo_head[DATA_MAX-1:0];
    assign RxParErr = fifo_head[DATA_MAX];
    assign RxFrmErr = fifo_head[DATA_MAX+1];
    assign RxValid  = ~fifo_empty;
    assign Overrun  = overrun_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo: Tick every 4 Clk, 16x oversampling, 8-bit words.
module tb_uart_rx_frame_fifo;

    localparam int BIT_CLKS = 64;

    logic       Clk;
    logic       Rst_n;
    logic       RxEn;
    logic       Rx;
    logic       Tick;
    logic [3:0] NBits;
    logic       ParityEn;
    logic       ParityOdd;
    logic       TwoStop;
    logic [7:0] RxData;
    logic       RxParErr;
    logic       RxFrmErr;
    logic       RxValid;
    logic       RxReady;
    logic       Overrun;
    logic       Busy;

    int errors = 0;
    int checks = 0;
    int ovr_total = 0;

    uart_rx_frame_fifo #(
        .DATA_MAX   (8),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .RxEn      (RxEn),
        .Rx        (Rx),
        .Tick      (Tick),
        .NBits     (NBits),
        .ParityEn  (ParityEn),
        .ParityOdd (ParityOdd),
        .TwoStop   (TwoStop),
        .RxData    (RxData),
        .RxParErr  (RxParErr),
        .RxFrmErr  (RxFrmErr),
        .RxValid   (RxValid),
        .RxReady   (RxReady),
        .Overrun   (Overrun),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One-Clk-wide Tick every fourth Clk.
    initial begin
        Tick = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            Tick = 1'b1;
            @(negedge Clk);
            Tick = 1'b0;
        end
    end

    // Running count of Overrun pulses.
    initial begin
        forever begin
            @(negedge Clk);
            if (Overrun === 1'b1) ovr_total++;
        end
    end

    // Global time limit.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (BIT_CLKS) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit pb,
                              input bit s1, input bit s2, input bit ts);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(s1);
        if (ts) drive_bit(s2);
        Rx = 1'b1;
    endtask

    task automatic set_cfg(input logic [3:0] nb, input bit pe, input bit po, input bit ts);
        NBits     = nb;
        ParityEn  = pe;
        ParityOdd = po;
        TwoStop   = ts;
    endtask

    task automatic wait_valid(input int max_clks, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_clks; i++) begin
            if (RxValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic pop_head();
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        RxEn = 1'b0;
        Rx = 1'b1;
        RxReady = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge Clk);
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", RxValid); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++;
        if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", Overrun); end
        checks++;
        if ({RxFrmErr, RxParErr, RxData} !== 10'h000) begin
            errors++; $display("FAIL reset_head: got %h expected 000", {RxFrmErr, RxParErr, RxData});
        end
        Rst_n = 1'b1;
        RxEn = 1'b1;
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_8n1();
        bit ok;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL 8n1_valid: got timeout expected RxValid=1"); end
        checks++;
        if ({RxFrmErr, RxParErr, RxData} !== {1'b0, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL 8n1_head: got frm=%b par=%b data=%h expected 0 0 5a", RxFrmErr, RxParErr, RxData);
        end
        repeat (20) @(negedge Clk);
        checks++;
        if (RxValid !== 1'b1 || RxData !== 8'h5A) begin
            errors++; $display("FAIL 8n1_hold: got valid=%b data=%h expected 1 5a", RxValid, RxData);
        end
        pop_head();
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL 8n1_pop: got valid=%b expected 0", RxValid); end
    endtask

    task automatic test_parity();
        bit ok;
        set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(200, ok);
        checks++;
        if (!ok || RxData !== 8'h41 || RxParErr !== 1'b0) begin
            errors++; $display("FAIL 7e1_good: got valid=%b data=%h par=%b expected 1 41 0", ok, RxData, RxParErr);
        end
        pop_head();
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_valid(200, ok);
        checks++;
        if (!ok || RxData !== 8'h41 || RxParErr !== 1'b1 || RxFrmErr !== 1'b0) begin
            errors++; $display("FAIL 7e1_bad: got valid=%b data=%h par=%b frm=%b expected 1 41 1 0",
                               ok, RxData, RxParErr, RxFrmErr);
        end
        pop_head();
    endtask

    task automatic test_frame_err();
        bit ok;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_valid(200, ok);
        checks++;
        if (!ok || RxData !== 8'hC3 || RxFrmErr !== 1'b1 || RxParErr !== 1'b0) begin
            errors++; $display("FAIL 8n2_frm: got valid=%b data=%h frm=%b par=%b expected 1 c3 1 0",
                               ok, RxData, RxFrmErr, RxParErr);
        end
        pop_head();
        repeat (40) @(negedge Clk);
        // Three-Tick low pulse on an idle line.
        Rx = 1'b0;
        repeat (12) @(negedge Clk);
        Rx = 1'b1;
        repeat (4) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy: got %b expected 1", Busy); end
        repeat (100) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || RxValid !== 1'b0) begin
            errors++; $display("FAIL glitch_reject: got busy=%b valid=%b expected 0 0", Busy, RxValid);
        end
    endtask

    task automatic test_vote();
        bit ok;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                Rx = 1'b1;
                repeat (32) @(negedge Clk);
                Rx = 1'b0;
                repeat (4) @(negedge Clk);
                Rx = 1'b1;
                repeat (BIT_CLKS - 36) @(negedge Clk);
            end else begin
                drive_bit(1'b1);
            end
        end
        drive_bit(1'b1);
        wait_valid(200, ok);
        checks++;
        if (!ok || RxData !== 8'hFF || RxFrmErr !== 1'b0) begin
            errors++; $display("FAIL vote_ff: got valid=%b data=%h frm=%b expected 1 ff 0", ok, RxData, RxFrmErr);
        end
        pop_head();
    endtask

    task automatic test_back_to_back();
        int ovr_before;
        logic [7:0] exp_data;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        RxReady = 1'b0;
        ovr_before = ovr_total;
        for (int f = 1; f <= 5; f++) begin
            exp_data = 8'(f);
            send_frame(exp_data, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        repeat (10) @(negedge Clk);
        checks++;
        if (ovr_total - ovr_before !== 1) begin
            errors++; $display("FAIL overrun_count: got %0d expected 1", ovr_total - ovr_before);
        end
        for (int f = 1; f <= 4; f++) begin
            exp_data = 8'(f);
            checks++;
            if (RxValid !== 1'b1 || RxData !== exp_data) begin
                errors++; $display("FAIL fifo_order_%0d: got valid=%b data=%h expected 1 %h", f, RxValid, RxData, exp_data);
            end
            pop_head();
        end
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got valid=%b expected 0", RxValid); end
    endtask

    task automatic test_abort_reset();
        bit ok;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        // Disable mid-data.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        Rx = 1'b0;
        repeat (20) @(negedge Clk);
        RxEn = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL rxen_abort_busy: got %b expected 0", Busy); end
        Rx = 1'b1;
        repeat (4) @(negedge Clk);
        RxEn = 1'b1;
        repeat (800) @(negedge Clk);
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL rxen_abort_push: got valid=%b expected 0", RxValid); end

        // Leave one word queued, then reset in the middle of the next frame.
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(200, ok);
        checks++;
        if (!ok || RxData !== 8'h77) begin
            errors++; $display("FAIL pre_reset_word: got valid=%b data=%h expected 1 77", ok, RxData);
        end
        drive_bit(1'b0);
        drive_bit(1'b1);
        Rx = 1'b0;
        repeat (10) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({RxValid, Busy, Overrun, RxFrmErr, RxParErr, RxData} !== 13'h0000) begin
            errors++; $display("FAIL reset_midframe: got valid=%b busy=%b ovr=%b frm=%b par=%b data=%h expected all 0",
                               RxValid, Busy, Overrun, RxFrmErr, RxParErr, RxData);
        end
        Rx = 1'b1;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(200, ok);
        checks++;
        if (!ok || {RxFrmErr, RxParErr, RxData} !== {1'b0, 1'b0, 8'h3C}) begin
            errors++; $display("FAIL post_reset_3c: got valid=%b frm=%b par=%b data=%h expected 1 0 0 3c",
                               ok, RxFrmErr, RxParErr, RxData);
        end
        pop_head();
        checks++;
        if (RxValid !== 1'b0) begin errors++; $display("FAIL post_reset_single: got valid=%b expected 0", RxValid); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_vote();
        test_back_to_back();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
